data_mem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory interface: it accepts load/store requests from the core, waits a programmable latency, then returns read data or a completion.
- It replaces the zero-latency data memory with a handshaked, multi-cycle slave, so the core's stall logic can be exercised.
- It holds one outstanding transaction at a time and contains a byte-enabled word array.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/be_word_ram.sv | 32 +++
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_data_mem_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: FSM states and
// word/byte-lane geometry.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   localparam int unsigned BE_W       = 4;
   localparam int unsigned WORD_BYTES = 4;
   localparam logic [31:0] ADDR_ALIGN_MASK = 32'(WORD_BYTES - 1);

endpackage

// File: rtl/be_word_ram.sv
// Synchronous single-port word array with per-byte write enables and a
// registered read port that only updates when the port is enabled.
module be_word_ram
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic [BE_W-1:0]   we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Read data is held while en_i is low so a pending response stays stable.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle, single-outstanding data-memory slave: accepts a load/store,
// waits LATENCY edges, commits to the array and holds the response.
module data_mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [31:0]     req_addr,
   input  logic [31:0]     req_wdata,
   input  logic [BE_W-1:0] req_be,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [31:0]     resp_rdata,
   output logic            resp_err
);

   localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(WORD_BYTES * DEPTH_WORDS);

   if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be in 1..15");
   end

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            wr_q;
   logic [31:0]     addr_q, wdata_q;
   logic [BE_W-1:0] be_q;
   logic            resp_valid_q, resp_err_q, rd_ok_q;

   logic            accept, commit;
   logic            cur_write, cur_err;
   logic [31:0]     cur_addr, cur_wdata;
   logic [BE_W-1:0] cur_be;
   logic [BE_W-1:0] ram_we;
   logic [31:0]     ram_rdata;

   // With LATENCY=1 the commit happens on the accept edge itself, so the
   // live request is used in IDLE and the captured copy everywhere else.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_write = req_write;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
         cur_be    = req_be;
      end else begin
         cur_write = wr_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_be    = be_q;
      end
      cur_err = ((cur_addr & ADDR_ALIGN_MASK) != '0) || (cur_addr >= ADDR_LIMIT);
      ram_we  = (commit && cur_write && !cur_err) ? cur_be : '0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(LATENCY - 2);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rd_ok_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
         if (commit) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= cur_err;
            rd_ok_q      <= !cur_write && !cur_err;
         end else if ((state_q == ST_RESP) && resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_ok_q      <= 1'b0;
         end
      end
   end

   be_word_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_ram (
      .clk_i   (clock),
      .en_i    (commit),
      .we_i    (ram_we),
      .addr_i  (cur_addr[ADDR_W+1:2]),
      .wdata_i (cur_wdata),
      .rdata_o (ram_rdata)
   );

   // The array's read register is not reset; rd_ok_q gates it to zero
   // for stores, errors, idle and reset.
   assign req_ready  = (state_q == ST_IDLE) && reset;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder: a LATENCY=2
// instance for the main scenarios and a LATENCY=1 instance for throughput.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned LAT0  = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid = 0, req_write = 0, resp_ready = 0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        r1_valid = 0, r1_write = 0, r1_resp_ready = 0;
   logic [31:0] r1_addr = '0, r1_wdata = '0;
   logic [3:0]  r1_be = '0;
   logic        r1_ready, r1_resp_valid, r1_err;
   logic [31:0] r1_rdata;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] model [2][DEPTH];

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut (
      .clock(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clock(clk), .reset(reset),
      .req_valid(r1_valid), .req_ready(r1_ready), .req_write(r1_write),
      .req_addr(r1_addr), .req_wdata(r1_wdata), .req_be(r1_be),
      .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready),
      .resp_rdata(r1_rdata), .resp_err(r1_err)
   );

   // Reference: memory as a plain word array, errors from address arithmetic.
   function automatic void model_access(input int d, input bit wr, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] be,
                                        output bit err, output logic [31:0] rd);
      int unsigned idx;
      err = (a % 4 != 0) || (a >= 4 * DEPTH);
      rd  = '0;
      if (err) return;
      idx = a / 4;
      if (wr) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
         rd = model[d][idx];
      end
   endfunction

   task automatic drive_txn(input int unsigned hold, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] got);
      bit          exp_err;
      logic [31:0] exp_rd;
      int          edges;
      model_access(0, wr, a, wd, be, exp_err, exp_rd);
      @(negedge clk);
      req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
      resp_ready = (hold == 0);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++; $display("FAIL idle_ready: got %b expected 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 0; req_addr = $urandom(); req_wdata = $urandom(); req_be = 4'($urandom());
      edges = 1;
      while (resp_valid !== 1'b1 && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      vectors++;
      if (edges != LAT0) begin
         miscompares++; $display("FAIL latency addr=%h: got %0d edges expected %0d", a, edges, LAT0);
      end
      vectors++;
      if (resp_err !== exp_err) begin
         miscompares++; $display("FAIL resp_err addr=%h: got %b expected %b", a, resp_err, exp_err);
      end
      vectors++;
      if (resp_rdata !== exp_rd) begin
         miscompares++; $display("FAIL resp_rdata addr=%h wr=%b: got %h expected %h", a, wr, resp_rdata, exp_rd);
      end
      got = resp_rdata;
      for (int i = 0; i < int'(hold); i++) begin
         if (i == 0) begin
            req_valid = 1; req_write = 1; req_addr = 32'h0; req_wdata = $urandom(); req_be = 4'hF;
         end
         @(posedge clk); #1;
         req_valid = 0;
         vectors++;
         if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_err !== exp_err || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_stable cyc=%0d: got v=%b rd=%h err=%b rdy=%b expected v=1 rd=%h err=%b rdy=0",
                     i, resp_valid, resp_rdata, resp_err, req_ready, exp_rd, exp_err);
         end
      end
      resp_ready = 1;
      @(posedge clk); #1;
      resp_ready = 0;
      vectors++;
      if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL handshake_clear: got v=%b err=%b rd=%h rdy=%b expected v=0 err=0 rd=0 rdy=1",
                  resp_valid, resp_err, resp_rdata, req_ready);
      end
   endtask

   task automatic test_reset;
      #1;
      vectors++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL in_reset: got rdy=%b v=%b err=%b rd=%h expected all 0", req_ready, resp_valid, resp_err, resp_rdata);
      end
      repeat (2) @(negedge clk);
      reset = 1;
      @(posedge clk); #1;
      vectors++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || r1_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL after_reset: got rdy=%b v=%b rdy1=%b expected 1 0 1", req_ready, resp_valid, r1_ready);
      end
   endtask

   task automatic test_store_load;
      logic [31:0] got;
      for (int w = 0; w < 16; w++) drive_txn(0, 1, 32'(4 * w), $urandom(), 4'hF, got);
      drive_txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, got);
      drive_txn(0, 0, 32'h10, 32'h0, 4'h0, got);
      vectors++;
      if (got !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL load_deadbeef: got %h expected deadbeef", got);
      end
   endtask

   task automatic test_partial;
      logic [31:0] got;
      drive_txn(0, 1, 32'h20, 32'h11223344, 4'hF, got);
      drive_txn(0, 1, 32'h20, 32'h0000AA00, 4'b0010, got);
      drive_txn(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, got);
      drive_txn(0, 0, 32'h20, 32'h0, 4'h0, got);
      vectors++;
      if (got !== 32'h1122AA44) begin
         miscompares++; $display("FAIL partial_store: got %h expected 1122aa44", got);
      end
   endtask

   task automatic test_errors;
      logic [31:0] got;
      drive_txn(0, 0, 32'h13, 32'h0, 4'h0, got);
      drive_txn(0, 1, 32'h400, 32'hCAFEF00D, 4'hF, got);
      drive_txn(0, 1, 32'h6, 32'h12345678, 4'hF, got);
      drive_txn(0, 0, 32'h0, 32'h0, 4'h0, got);
      drive_txn(0, 0, 32'h3FC, 32'h0, 4'h0, got);
      drive_txn(0, 0, 32'h8000_0000, 32'h0, 4'h0, got);
   endtask

   task automatic test_backpressure;
      logic [31:0] got;
      drive_txn(5, 0, 32'h10, 32'h0, 4'h0, got);
      drive_txn(5, 1, 32'h24, 32'h5A5AA5A5, 4'hF, got);
      drive_txn(0, 0, 32'h0, 32'h0, 4'h0, got);
   endtask

   task automatic test_reset_mid_txn;
      logic [31:0] got, dummy;
      bit          e;
      // Store dropped in WAIT: never written.
      @(negedge clk);
      req_valid = 1; req_write = 1; req_addr = 32'h30; req_wdata = 32'hBAD0BAD0; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 0;
      reset = 0;
      #1;
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_mid_wait: got v=%b rdy=%b expected 0 0", resp_valid, req_ready);
      end
      @(negedge clk); reset = 1;
      @(posedge clk); #1;
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_release: got v=%b rdy=%b expected 0 1", resp_valid, req_ready);
      end
      drive_txn(0, 0, 32'h30, 32'h0, 4'h0, got);
      // Store already committed in RESP: survives reset.
      @(negedge clk);
      req_valid = 1; req_write = 1; req_addr = 32'h34; req_wdata = 32'h0BADF00D; req_be = 4'hF;
      resp_ready = 0;
      @(posedge clk); #1;
      req_valid = 0;
      @(posedge clk); #1;
      model_access(0, 1, 32'h34, 32'h0BADF00D, 4'hF, e, dummy);
      vectors++;
      if (resp_valid !== 1'b1) begin
         miscompares++; $display("FAIL resp_before_reset: got %b expected 1", resp_valid);
      end
      reset = 0;
      @(negedge clk); reset = 1;
      drive_txn(0, 0, 32'h34, 32'h0, 4'h0, got);
   endtask

   task automatic test_random;
      logic [31:0] got, a;
      int unsigned sel;
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)      a = 32'(4 * $urandom_range(0, 15));
         else if (sel < 9) a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
         else              a = 32'h400 + 32'($urandom_range(0, 4095));
         drive_txn($urandom_range(0, 3), 1'($urandom()), a, $urandom(), 4'($urandom()), got);
      end
   endtask

   task automatic test_lat1_back_to_back;
      bit          exp_err;
      logic [31:0] exp_rd, a;
      bit          wr;
      r1_resp_ready = 1;
      r1_valid = 1;
      for (int k = 0; k < 16; k++) begin
         wr = (k < 8);
         a  = wr ? 32'(4 * k) : 32'(4 * $urandom_range(0, 7));
         @(negedge clk);
         r1_write = wr; r1_addr = a; r1_wdata = $urandom(); r1_be = 4'hF;
         model_access(1, wr, a, r1_wdata, r1_be, exp_err, exp_rd);
         vectors++;
         if (r1_ready !== 1'b1) begin
            miscompares++; $display("FAIL lat1_ready k=%0d: got %b expected 1", k, r1_ready);
         end
         @(posedge clk); #1;
         vectors++;
         if (r1_resp_valid !== 1'b1 || r1_rdata !== exp_rd || r1_err !== exp_err) begin
            miscompares++;
            $display("FAIL lat1_resp k=%0d: got v=%b rd=%h err=%b expected v=1 rd=%h err=%b",
                     k, r1_resp_valid, r1_rdata, r1_err, exp_rd, exp_err);
         end
         @(posedge clk); #1;
         vectors++;
         if (r1_resp_valid !== 1'b0 || r1_ready !== 1'b1) begin
            miscompares++; $display("FAIL lat1_turnaround k=%0d: got v=%b rdy=%b expected 0 1", k, r1_resp_valid, r1_ready);
         end
      end
      r1_valid = 0;
      r1_resp_ready = 0;
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_partial();
      test_errors();
      test_backpressure();
      test_reset_mid_txn();
      test_random();
      test_lat1_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
